// File: rtl/glide_quant_pkg.sv
// glide_quant_pkg: shared constants and the per-stage beat record for the
// dequantisation stream. No ports; imported by dequant_stream and
// dequant_scale_table.
package glide_quant_pkg;

  localparam int NUM_CH     = 16;   // default channel-table depth
  localparam int OUT_W      = 32;   // default output width
  localparam int MAX_SHIFT  = 40;   // shift_amount is clamped to this
  localparam int SCALE_W    = 32;   // per-channel scale width
  localparam int ZP_W       = 8;    // per-channel zero-point width
  localparam int PROD_W     = 41;   // 9-bit diff x 32-bit scale
  localparam int SHIFT_W    = 6;    // holds 0..MAX_SHIFT
  localparam int CH_FIELD_W = 8;    // wide enough for up to 256 channels

  // One pipeline beat. 'data' holds the diff in S1 (sign-extended) and the
  // product in S2; it is stored unsigned and reinterpreted with $signed.
  typedef struct packed {
    logic [PROD_W-1:0]     data;
    logic [CH_FIELD_W-1:0] ch;
    logic                  last;
    logic [SHIFT_W-1:0]    shift;
    logic                  valid;
  } beat_t;

  function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [7:0] s);
    return (s > 8'(MAX_SHIFT)) ? SHIFT_W'(MAX_SHIFT) : s[SHIFT_W-1:0];
  endfunction

endpackage

// File: rtl/dequant_scale_table.sv
// dequant_scale_table: per-channel scale / zero-point storage.
// Ports: clk/rst (async active-high), one write port (we_i, waddr_i,
// wscale_i, wzp_i), one combinational read port (raddr_i -> rscale_o, rzp_o).
// A write lands on the clock edge, so a same-cycle read still sees the old entry.
module dequant_scale_table #(
  parameter int NUM_CH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we_i,
  input  logic [$clog2(NUM_CH)-1:0] waddr_i,
  input  logic [31:0]               wscale_i,
  input  logic [7:0]                wzp_i,
  input  logic [$clog2(NUM_CH)-1:0] raddr_i,
  output logic [31:0]               rscale_o,
  output logic [7:0]                rzp_o
);
  import glide_quant_pkg::*;

  logic [SCALE_W-1:0] scale_q [NUM_CH];
  logic [ZP_W-1:0]    zp_q    [NUM_CH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        scale_q[i] <= '0;
        zp_q[i]    <= '0;
      end
    end else if (we_i) begin
      scale_q[waddr_i] <= wscale_i;
      zp_q[waddr_i]    <= wzp_i;
    end
  end

  assign rscale_o = scale_q[raddr_i];
  assign rzp_o    = zp_q[raddr_i];

endmodule

// File: rtl/dequant_stream.sv
// dequant_stream: int8 -> OUT_W dequantiser, out = sat(round((in - zp[ch]) * scale[ch] >>> shift)).
// Latency 3 cycles, 1 beat/cycle; single global stall: every stage holds when
// en is low or the output is valid but not taken (in_ready = en && (!out_valid || out_ready)).
// Ports: cfg_* write the channel table (always, even with en low); num_ch sets the
// channel rotation; in_* / out_* are valid-ready streams with last and saturation flags.
module dequant_stream #(
  parameter int NUM_CH = glide_quant_pkg::NUM_CH,
  parameter int OUT_W  = glide_quant_pkg::OUT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      cfg_we,
  input  logic [$clog2(NUM_CH)-1:0] cfg_addr,
  input  logic [31:0]               cfg_scale,
  input  logic [7:0]                cfg_zp,
  input  logic [$clog2(NUM_CH):0]   num_ch,
  input  logic [7:0]                shift_amount,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [7:0]                in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_W-1:0]          out_data,
  output logic [$clog2(NUM_CH)-1:0] out_ch,
  output logic                      out_last,
  output logic                      out_sat
);
  import glide_quant_pkg::*;

  localparam int CH_W = $clog2(NUM_CH);
  localparam logic [CH_W:0] CH_FULL = (CH_W+1)'(NUM_CH);
  localparam logic signed [63:0] OUT_MAX = (64'sd1 <<< (OUT_W-1)) - 64'sd1;
  localparam logic signed [63:0] OUT_MIN = -(64'sd1 <<< (OUT_W-1));

  logic adv, accept;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [CH_W:0]      n_eff, ch_inc;
  logic [SCALE_W-1:0] tbl_scale;
  logic [ZP_W-1:0]    tbl_zp;
  logic signed [8:0]  diff;

  beat_t              s1_q, s1_d, s2_q, s2_d;
  logic [SCALE_W-1:0] s1_scale_q;

  logic signed [PROD_W:0] prod_x, rnd_add, rnd_sum, shifted;
  logic signed [63:0]     res_wide;
  logic [OUT_W-1:0]       out_data_q, out_data_d;
  logic [CH_W-1:0]        out_ch_q;
  logic                   out_valid_q, out_last_q, out_sat_q, out_sat_d;
  logic                   unused_ch_hi;

  // Every stage moves together, so a stall anywhere freezes the whole pipe.
  assign adv      = en && (!out_valid_q || out_ready);
  assign in_ready = adv;
  assign accept   = in_valid && adv;

  dequant_scale_table #(.NUM_CH(NUM_CH)) u_table (
    .clk      (clk),
    .rst      (rst),
    .we_i     (cfg_we),
    .waddr_i  (cfg_addr),
    .wscale_i (cfg_scale),
    .wzp_i    (cfg_zp),
    .raddr_i  (ch_q),
    .rscale_o (tbl_scale),
    .rzp_o    (tbl_zp)
  );

  // Channel rotation; out-of-range counts mean "use the whole table", and
  // a frame end restarts at channel 0 regardless of where the rotation is.
  always_comb begin
    n_eff  = (num_ch == '0 || num_ch > CH_FULL) ? CH_FULL : num_ch;
    ch_inc = {1'b0, ch_q} + (CH_W+1)'(1);
    ch_d   = ch_q;
    if (accept) begin
      if (in_last || ch_inc >= n_eff) ch_d = '0;
      else                            ch_d = ch_inc[CH_W-1:0];
    end
  end

  // S1: lookup and zero-point subtraction (9 bits covers -255..255).
  assign diff = $signed({in_data[7], in_data}) - $signed({tbl_zp[7], tbl_zp});

  always_comb begin
    s1_d       = '0;
    s1_d.valid = in_valid;
    s1_d.data  = PROD_W'(diff);
    s1_d.ch    = CH_FIELD_W'(ch_q);
    s1_d.last  = in_last;
    s1_d.shift = clamp_shift(shift_amount);
  end

  // S2: full-precision product; |prod| < 2^39 so 41 bits never overflows.
  always_comb begin
    s2_d      = s1_q;
    s2_d.data = $signed(s1_q.data)
              * $signed({{(PROD_W-SCALE_W){s1_scale_q[SCALE_W-1]}}, s1_scale_q});
  end

  // S3: round-half-up by adding half an LSB before the arithmetic shift,
  // then clamp into the signed OUT_W range.
  always_comb begin
    prod_x  = $signed({s2_q.data[PROD_W-1], s2_q.data});
    rnd_add = '0;
    if (s2_q.shift != '0) rnd_add = (PROD_W+1)'(1) <<< (s2_q.shift - SHIFT_W'(1));
    rnd_sum  = prod_x + rnd_add;
    shifted  = rnd_sum >>> s2_q.shift;
    res_wide = 64'(shifted);
    out_data_d = res_wide[OUT_W-1:0];
    out_sat_d  = 1'b0;
    if (res_wide > OUT_MAX) begin
      out_data_d = OUT_MAX[OUT_W-1:0];
      out_sat_d  = 1'b1;
    end else if (res_wide < OUT_MIN) begin
      out_data_d = OUT_MIN[OUT_W-1:0];
      out_sat_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_q        <= '0;
      s1_q        <= '0;
      s1_scale_q  <= '0;
      s2_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
      out_sat_q   <= 1'b0;
    end else if (adv) begin
      ch_q        <= ch_d;
      s1_q        <= s1_d;
      s1_scale_q  <= tbl_scale;
      s2_q        <= s2_d;
      out_valid_q <= s2_q.valid;
      out_data_q  <= out_data_d;
      out_ch_q    <= s2_q.ch[CH_W-1:0];
      out_last_q  <= s2_q.last;
      out_sat_q   <= out_sat_d;
    end
  end

  // The beat's channel field is sized for the largest table.
  assign unused_ch_hi = ^s2_q.ch;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_last  = out_last_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_dequant_stream.sv
// tb_dequant_stream: randomized and directed stimulus for dequant_stream,
// checked against an arithmetic reference model (channel tables, channel
// rotation, round/shift/saturate on 64-bit integers) and a FIFO of expectations.
module tb_dequant_stream;

  localparam int NUM_CH = 16;
  localparam int OUT_W  = 32;

  logic        clk, rst, en, cfg_we;
  logic [3:0]  cfg_addr;
  logic [31:0] cfg_scale;
  logic [7:0]  cfg_zp;
  logic [4:0]  num_ch;
  logic [7:0]  shift_amount;
  logic        in_valid, in_ready, in_last;
  logic [7:0]  in_data;
  logic        out_valid, out_ready, out_last, out_sat;
  logic [31:0] out_data;
  logic [3:0]  out_ch;

  dequant_stream #(.NUM_CH(NUM_CH), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_scale(cfg_scale), .cfg_zp(cfg_zp), .num_ch(num_ch),
    .shift_amount(shift_amount), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .out_last(out_last), .out_sat(out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          ch;
    logic        last;
    logic        sat;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] mscale [NUM_CH];
  logic [7:0]  mzp    [NUM_CH];
  int          mch;
  int          n_chk, n_pass, n_out;
  logic        acc, stall_prev;
  logic [31:0] last_data;
  int          last_ch;
  logic        last_sat;
  int          obs_ch[$];
  logic        obs_last[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  function automatic int eff_n(input logic [4:0] n);
    return (n == 0 || n > NUM_CH) ? NUM_CH : int'(n);
  endfunction

  function automatic exp_t model(input logic [7:0] d, input logic [7:0] zp,
                                 input logic [31:0] sc, input logic [7:0] sh,
                                 input int ch, input logic lst);
    exp_t   e;
    longint diff, prod, r;
    int     s;
    diff = longint'($signed(d)) - longint'($signed(zp));
    prod = diff * longint'($signed(sc));
    s    = (sh > 40) ? 40 : int'(sh);
    r    = (s > 0) ? ((prod + (longint'(1) <<< (s - 1))) >>> s) : prod;
    e.ch = ch; e.last = lst; e.sat = 1'b0;
    if (r > 64'sd2147483647) begin
      e.data = 32'h7FFF_FFFF; e.sat = 1'b1;
    end else if (r < -64'sd2147483648) begin
      e.data = 32'h8000_0000; e.sat = 1'b1;
    end else begin
      e.data = r[31:0];
    end
    return e;
  endfunction

  // One cycle: inputs were set at the preceding negedge; observe the
  // handshakes that the next posedge will complete, update the model, advance.
  task automatic step();
    exp_t e;
    acc = 1'b0;
    #1;
    if (!en) chk("in_ready_en_low", in_ready, 0);
    else if (out_ready) chk("in_ready_out_rdy", in_ready, 1);
    if (stall_prev) chk("hold_valid", out_valid, 1);
    if (out_valid && out_ready) begin
      n_out++;
      if (expq.size() == 0) begin
        chk("spurious_out", 1, 0);
      end else begin
        e = expq.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_ch",   out_ch,   64'(e.ch));
        chk("out_last", out_last, e.last);
        chk("out_sat",  out_sat,  e.sat);
      end
      last_data = out_data; last_ch = int'(out_ch); last_sat = out_sat;
      obs_ch.push_back(int'(out_ch));
      obs_last.push_back(out_last);
    end
    stall_prev = out_valid && !out_ready;
    if (in_valid && in_ready) begin
      acc = 1'b1;
      expq.push_back(model(in_data, mzp[mch], mscale[mch], shift_amount, mch, in_last));
      if (in_last || mch + 1 >= eff_n(num_ch)) mch = 0;
      else mch++;
    end
    if (cfg_we) begin
      mscale[cfg_addr] = cfg_scale;
      mzp[cfg_addr]    = cfg_zp;
    end
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_out_ch",    out_ch,    0);
    chk("rst_out_last",  out_last,  0);
    chk("rst_out_sat",   out_sat,   0);
    expq.delete();
    mch = 0; stall_prev = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin mscale[i] = '0; mzp[i] = '0; end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cfg(input logic [3:0] a, input logic [31:0] s, input logic [7:0] z);
    cfg_we = 1'b1; cfg_addr = a; cfg_scale = s; cfg_zp = z;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] sh, input logic lst);
    in_valid = 1'b1; in_data = d; shift_amount = sh; in_last = lst;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) step();
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1; en = 1'b1;
    for (int i = 0; i < 40 && expq.size() != 0; i++) step();
    chk("drain_empty", 64'(expq.size()), 0);
    for (int i = 0; i < 4; i++) step();
  endtask

  initial begin
    int lat, idx, cyc, n0;
    int exp42[7];
    n_chk = 0; n_pass = 0; n_out = 0;
    rst = 1'b0; en = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_scale = '0; cfg_zp = '0;
    num_ch = 5'd16; shift_amount = '0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    out_ready = 1'b1; stall_prev = 1'b0; mch = 0;
    @(negedge clk);
    reset_dut();
    en = 1'b1;

    // Identity mapping, latency and the most negative input.
    cfg(4'd0, 32'd1, 8'd0);
    send(8'h80, 8'd0, 1'b1);
    lat = 1;
    while (!out_valid && lat < 10) begin step(); lat++; end
    chk("req038_latency", 64'(lat), 3);
    drain();
    chk("req038_data", last_data, 32'hFFFF_FF80);
    chk("req038_ch",   64'(last_ch), 0);
    chk("req038_sat",  last_sat, 0);

    // Round-half-up on positive and negative halves.
    num_ch = 5'd1;
    cfg(4'd0, 32'd3, 8'd5);
    send(8'd6, 8'd1, 1'b0);
    drain();
    chk("req039_pos", last_data, 32'd2);
    send(8'd4, 8'd1, 1'b0);
    drain();
    chk("req039_neg", last_data, 32'hFFFF_FFFF);

    // Saturation at both rails.
    cfg(4'd0, 32'h7FFF_FFFF, 8'h80);
    send(8'd127, 8'd0, 1'b0);
    drain();
    chk("req040_max", last_data, 32'h7FFF_FFFF);
    chk("req040_max_sat", last_sat, 1);
    cfg(4'd0, 32'h7FFF_FFFF, 8'd127);
    send(8'h80, 8'd0, 1'b0);
    drain();
    chk("req040_min", last_data, 32'h8000_0000);
    chk("req040_min_sat", last_sat, 1);
    send(8'd3, 8'd45, 1'b0);   // shift clamps to 40
    drain();

    // Back-to-back stream with a downstream stall in cycles 5..9.
    cfg(4'd0, 32'd1, 8'd0);
    n0 = n_out; idx = 1; cyc = 0;
    while (idx <= 20 && cyc < 200) begin
      in_valid = 1'b1; in_data = 8'(idx); shift_amount = 8'd0;
      out_ready = !(cyc >= 5 && cyc <= 9);
      if (cyc >= 5 && cyc <= 9) begin
        #1;
        chk("req041_rdy_low", in_ready, 0);
      end
      step();
      if (acc) idx++;
      cyc++;
    end
    drain();
    chk("req041_count", 64'(n_out - n0), 20);
    chk("req041_last", last_data, 32'd20);

    // Channel rotation with a frame end on beat 5.
    num_ch = 5'd3;
    obs_ch.delete(); obs_last.delete();
    for (int i = 1; i <= 7; i++) send(8'(i), 8'd0, (i == 5));
    drain();
    exp42 = '{0, 1, 2, 0, 1, 0, 1};
    chk("req042_count", 64'(obs_ch.size()), 7);
    for (int i = 0; i < 7 && i < obs_ch.size(); i++) begin
      chk("req042_ch", 64'(obs_ch[i]), 64'(exp42[i]));
      chk("req042_last", obs_last[i], (i == 4));
    end

    // Reset with beats in flight: one held at the output, one behind it.
    out_ready = 1'b0;
    send(8'd11, 8'd0, 1'b0);
    send(8'd12, 8'd0, 1'b0);
    step();
    chk("req043_pre_valid", out_valid, 1);
    reset_dut();
    en = 1'b1; out_ready = 1'b1;
    n0 = n_out;
    send(8'd50, 8'd0, 1'b0);
    drain();
    chk("req043_count", 64'(n_out - n0), 1);
    chk("req043_ch",    64'(last_ch), 0);
    chk("req043_data",  last_data, 0);

    // Randomized traffic with config writes, enables, stalls and frame ends.
    num_ch = 5'd16;
    for (int c = 0; c < 1500; c++) begin
      en           = ($urandom_range(0, 7) != 0);
      out_ready    = en && ($urandom_range(0, 3) != 0);
      in_valid     = ($urandom_range(0, 2) != 0);
      in_data      = 8'($urandom);
      in_last      = ($urandom_range(0, 9) == 0);
      shift_amount = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 40));
      cfg_we       = ($urandom_range(0, 5) == 0);
      cfg_addr     = 4'($urandom);
      cfg_scale    = ($urandom_range(0, 1) != 0) ? $urandom
                                                 : 32'($urandom_range(0, 2000)) - 32'd1000;
      cfg_zp       = 8'($urandom);
      if (c % 150 == 0) num_ch = 5'($urandom);
      step();
    end
    cfg_we = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dequant_stream.md
DEQUANT_STREAM -- requirements
Module: dequant_stream

Interface
REQ-001 SHALL have parameter NUM_CH, default 16: number of per-channel scale/zero-point entries (power of 2, 2..256).
REQ-002 SHALL have parameter OUT_W, default 32: output width.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 en  in  1  global pipeline enable; low freezes all state except config writes.
REQ-006 cfg_we  in  1  config table write strobe.
REQ-007 cfg_addr  in  log2(NUM_CH)  channel index for write.
REQ-008 cfg_scale  in  32  signed per-channel scale.
REQ-009 cfg_zp  in  8  signed per-channel zero point.
REQ-010 num_ch  in  log2(NUM_CH)+1  active channel count.
REQ-011 shift_amount  in  8  right shift applied after multiply.
REQ-012 in_valid / in_ready  in / out  1  input handshake.
REQ-013 in_data  in  8  signed int8 sample.
REQ-014 in_last  in  1  final beat of frame.
REQ-015 out_valid / out_ready  out / in  1  output handshake.
REQ-016 out_data  out  OUT_W  signed dequantized value.
REQ-017 out_ch  out  log2(NUM_CH)  channel of out_data.
REQ-018 out_last  out  1  in_last carried through the pipeline.
REQ-019 out_sat  out  1  out_data was saturated.

Function
REQ-020 Beat accepted when in_valid && in_ready; in_ready SHALL equal en && (!out_valid || out_ready).
REQ-021 Three-stage pipeline: S1 table lookup and diff = in_data - zp[ch] (9-bit signed); S2 prod = diff * scale (41-bit signed); S3 round, shift, saturate.
REQ-022 Latency: out_valid SHALL rise 3 cycles after acceptance absent stall; throughput 1 beat/cycle.
REQ-023 Pipeline advances only when in_ready is high; stalled stages hold contents; no beat dropped, duplicated or reordered.
REQ-024 out_data and companions SHALL remain stable while out_valid && !out_ready.
REQ-025 shift_amount SHALL be sampled at acceptance and carried with the beat; values >40 clamp to 40.
REQ-026 Rounding: round-half-up, result = (prod + (s>0 ? 2^(s-1) : 0)) >>> s, arithmetic shift.
REQ-027 Result outside OUT_W signed range SHALL clamp to max/min, with out_sat=1 for that beat.
REQ-028 Channel counter starts at 0, increments per accepted beat, wraps to 0 after num_ch-1.
REQ-029 Accepted beat with in_last SHALL force the counter to 0 for the next beat, overriding wrap.
REQ-030 num_ch of 0 or >NUM_CH SHALL be treated as NUM_CH.
REQ-031 Config write takes effect for lookups in the following cycle; same-cycle write and S1 read of one entry SHALL use the old value.
REQ-032 Config writes SHALL proceed regardless of en.

Reset
REQ-033 rst SHALL clear all stage valids, out_valid=0, out_data=0, out_ch=0, out_last=0, out_sat=0, channel counter=0.
REQ-034 rst SHALL clear every scale and zp entry to 0.
REQ-035 rst mid-stream SHALL discard all in-flight beats; first beat after release is channel 0.

Structure
REQ-036 Shared package glide_quant_pkg SHALL hold NUM_CH, OUT_W, MAX_SHIFT=40 and the per-stage beat struct (data, ch, last, shift, valid).
REQ-037 Config storage SHALL be one sub-module, dequant_scale_table (write port, one combinational read port, async reset).

Verification
REQ-038 zp[0]=0, scale[0]=1, shift=0, in=-128 -> out_data=-128, out_ch=0, out_sat=0, 3 cycles after acceptance.
REQ-039 zp=5, scale=3, shift=1; in=6 -> 2; in=4 -> -1 (round-half-up).
REQ-040 scale=0x7FFFFFFF, shift=0: zp=-128, in=127 -> 0x7FFFFFFF, out_sat=1; zp=127, in=-128 -> 0x80000000, out_sat=1.
REQ-041 Continuous stream 1..20, out_ready low for cycles 5-9 -> in_ready low those cycles, outputs 1..20 exactly once in order.
REQ-042 num_ch=3, seven beats, in_last on beat 5 -> out_ch 0,1,2,0,1,0,1 and out_last only on beat 5.
REQ-043 rst asserted with 2 beats in flight -> outputs cleared immediately, no stale beat emitted, next beat out_ch=0 and table reads 0.
